// File: rtl/host_bus_bridge.sv
// host_bus_bridge: decodes a byte-stream command protocol (word write, burst
// write, word read) into single-cycle bus transactions for the 6502 subsystem
// and returns acknowledge / read-data bytes to a UART transmitter.
module host_bus_bridge #(
    parameter int address_width = 15,
    parameter int data_width    = 16,
    parameter int ReadLatency   = 1,
    parameter int TimeoutCycles = 50000000
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [address_width-1:0] address_o,
    output logic [data_width-1:0]    data_o,
    output logic                     rd_wr_o,
    input  logic [data_width-1:0]    data_i,
    output logic                     busy_o
);

    localparam int TimerW = $clog2(TimeoutCycles + 1);
    localparam int LatW   = $clog2(ReadLatency + 1) + 1;

    typedef enum logic [3:0] {
        IDLE, ADDR_H, ADDR_L, CNT, DATA_H, DATA_L, WRITE, RD_WAIT, RESP_H, RESP_L, ACK
    } state_t;

    typedef enum logic [1:0] {CMD_W, CMD_B, CMD_R} cmd_t;

    state_t                   state_q, state_d;
    cmd_t                     cmd_q, cmd_d;
    logic [7:0]               hi_q, hi_d;          // holds AH, later DH
    logic [address_width-1:0] addr_q, addr_d;      // current transaction address
    logic [8:0]               count_q, count_d;    // burst words remaining after the current one
    logic [TimerW-1:0]        timer_q, timer_d;
    logic [LatW-1:0]          lat_q, lat_d;
    logic [7:0]               resp_lo_q, resp_lo_d;
    logic [address_width-1:0] address_q, address_d;
    logic [data_width-1:0]    data_q, data_d;
    logic                     rd_wr_q, rd_wr_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d;

    logic [15:0] rd_word;
    logic        rx_state;
    logic        tx_accept;

    assign rd_word   = 16'(data_i);
    assign tx_accept = tx_valid_q && tx_ready_i;
    assign rx_state  = (state_q == ADDR_H) || (state_q == ADDR_L) || (state_q == CNT) ||
                       (state_q == DATA_H) || (state_q == DATA_L);

    // Next-state, datapath and output decode for the command FSM
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        count_d    = count_q;
        timer_d    = '0;
        lat_d      = lat_q;
        resp_lo_d  = resp_lo_q;
        address_d  = address_q;
        data_d     = data_q;
        rd_wr_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    case (rx_data_i)
                        8'h57:   begin cmd_d = CMD_W; state_d = ADDR_H; end
                        8'h42:   begin cmd_d = CMD_B; state_d = ADDR_H; end
                        8'h52:   begin cmd_d = CMD_R; state_d = ADDR_H; end
                        default: state_d = IDLE;
                    endcase
                end
            end
            ADDR_H: begin
                if (rx_valid_i) begin
                    hi_d    = rx_data_i;
                    state_d = ADDR_L;
                end
            end
            ADDR_L: begin
                if (rx_valid_i) begin
                    if (cmd_q == CMD_R) begin
                        // Address goes onto the bus immediately for the read
                        address_d = address_width'({hi_q, rx_data_i});
                        lat_d     = '0;
                        state_d   = RD_WAIT;
                    end else begin
                        addr_d  = address_width'({hi_q, rx_data_i});
                        state_d = (cmd_q == CMD_B) ? CNT : DATA_H;
                    end
                end
            end
            CNT: begin
                if (rx_valid_i) begin
                    count_d = {1'b0, rx_data_i};
                    state_d = DATA_H;
                end
            end
            DATA_H: begin
                if (rx_valid_i) begin
                    hi_d    = rx_data_i;
                    state_d = DATA_L;
                end
            end
            DATA_L: begin
                if (rx_valid_i) begin
                    // Address, data and strobe all become valid together in WRITE
                    address_d = addr_q;
                    data_d    = data_width'({hi_q, rx_data_i});
                    rd_wr_d   = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if ((cmd_q == CMD_B) && (count_q != 9'd0)) begin
                    count_d = count_q - 9'd1;
                    addr_d  = addr_q + address_width'(1);
                    state_d = DATA_H;
                end else begin
                    tx_data_d  = 8'h4B;
                    tx_valid_d = 1'b1;
                    state_d    = ACK;
                end
            end
            RD_WAIT: begin
                // Address was presented on entry; data_i is valid ReadLatency cycles later
                if (lat_q == LatW'(ReadLatency)) begin
                    tx_data_d  = rd_word[15:8];
                    resp_lo_d  = rd_word[7:0];
                    tx_valid_d = 1'b1;
                    state_d    = RESP_H;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            RESP_H: begin
                if (tx_accept) begin
                    tx_data_d = resp_lo_q;
                    state_d   = RESP_L;
                end
            end
            RESP_L, ACK: begin
                if (tx_accept) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte timeout: only runs while waiting for command bytes
        if (rx_state && !rx_valid_i) begin
            if (timer_q == TimerW'(TimeoutCycles - 1)) begin
                state_d = IDLE;
            end else begin
                timer_d = timer_q + TimerW'(1);
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_W;
            hi_q       <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            lat_q      <= '0;
            resp_lo_q  <= '0;
            address_q  <= '0;
            data_q     <= '0;
            rd_wr_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            lat_q      <= lat_d;
            resp_lo_q  <= resp_lo_d;
            address_q  <= address_d;
            data_q     <= data_d;
            rd_wr_q    <= rd_wr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign address_o  = address_q;
    assign data_o     = data_q;
    assign rd_wr_o    = rd_wr_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_host_bus_bridge.sv
// Bench for host_bus_bridge: directed scenarios plus randomized commands,
// checked against a transaction-level protocol model and a shadow memory.
module tb_host_bus_bridge;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int RL = 1;
    localparam int TO = 100;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic          rx_valid_i = 1'b0;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i = 1'b0;
    logic [AW-1:0] address_o;
    logic [DW-1:0] data_o;
    logic          rd_wr_o;
    logic [DW-1:0] data_i = '0;
    logic          busy_o;

    host_bus_bridge #(
        .address_width(AW),
        .data_width   (DW),
        .ReadLatency  (RL),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .rx_data_i (rx_data_i),
        .rx_valid_i(rx_valid_i),
        .tx_data_o (tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .address_o (address_o),
        .data_o    (data_o),
        .rd_wr_o   (rd_wr_o),
        .data_i    (data_i),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // System memory behind the bus (registered read, one cycle latency)
    logic [15:0] bus_mem   [0:(1<<AW)-1];
    // Model's view of what memory must contain
    logic [15:0] model_mem [0:(1<<AW)-1];

    always @(posedge clk_i) begin
        data_i <= bus_mem[address_o];
        if (rd_wr_o) bus_mem[address_o] <= data_o;
    end

    typedef struct {logic [AW-1:0] a; logic [15:0] d;} wr_t;
    typedef struct {logic [7:0] b; bit rd_hi; logic [AW-1:0] a;} tx_t;

    wr_t         exp_wr[$];
    tx_t         exp_tx[$];
    wr_t         got_wr[$];
    logic [7:0]  got_tx[$];
    logic [15:0] bw[$];
    bit          hold_ready = 1'b0;
    bit          mon_en = 1'b0;
    logic [7:0]  junk [0:6] = '{8'h57, 8'h00, 8'h05, 8'h12, 8'h34, 8'h4B, 8'h52};

    function automatic void exp_write(input logic [AW-1:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
        model_mem[a] = d;
    endfunction

    function automatic void exp_byte(input logic [7:0] b, input bit rd_hi, input logic [AW-1:0] a);
        tx_t t;
        t.b = b;
        t.rd_hi = rd_hi;
        t.a = a;
        exp_tx.push_back(t);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat ($urandom_range(3, 0)) @(negedge clk_i);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        exp_write(AW'(a), d);
        exp_byte(8'h4B, 1'b0, '0);
        send_byte(8'h57);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    // Burst of the words currently in bw, starting at a
    task automatic do_burst(input logic [15:0] a);
        logic [7:0]    n;
        logic [AW-1:0] base;
        logic [15:0]   w;
        n    = 8'(bw.size() - 1);
        base = AW'(a);
        for (int i = 0; i < bw.size(); i++) exp_write(AW'((int'(base) + i) % (1 << AW)), bw[i]);
        exp_byte(8'h4B, 1'b0, '0);
        send_byte(8'h42);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(n);
        for (int i = 0; i < bw.size(); i++) begin
            w = bw[i];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
    endtask

    task automatic do_read(input logic [15:0] a);
        logic [15:0] v;
        v = model_mem[AW'(a)];
        exp_byte(v[15:8], 1'b1, AW'(a));
        exp_byte(v[7:0], 1'b0, AW'(a));
        send_byte(8'h52);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_o || exp_wr.size() != 0 || exp_tx.size() != 0) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: busy=%0d pending_wr=%0d pending_tx=%0d after %0d cycles, required idle",
                     busy_o, exp_wr.size(), exp_tx.size(), n);
        end
    endtask

    task automatic clear_logs();
        got_wr.delete();
        got_tx.delete();
    endtask

    // Transmit handshake: random backpressure unless a hold is requested
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            tx_ready_i = hold_ready ? 1'b0 : ($urandom_range(3, 0) != 0);
        end
    end

    // Compare process: bus writes and transmitted bytes against the model
    initial begin
        logic  prev_v, prev_r, prev_w;
        logic [7:0] prev_d;
        wr_t   ew;
        tx_t   et;
        prev_v = 1'b0; prev_r = 1'b0; prev_w = 1'b0; prev_d = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!reset_ni || !mon_en) begin
                prev_v = 1'b0;
                prev_w = 1'b0;
            end else begin
                if (rd_wr_o) begin
                    chk("write_single_cycle", 32'(prev_w), 32'd0);
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, no write expected",
                                 address_o, data_o);
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("write_addr", 32'(address_o), 32'(ew.a));
                        chk("write_data", 32'(data_o), 32'(ew.d));
                    end
                    ew.a = address_o;
                    ew.d = data_o;
                    got_wr.push_back(ew);
                end
                if (prev_v && !prev_r) begin
                    chk("tx_valid_hold", 32'(tx_valid_o), 32'd1);
                    chk("tx_data_hold", 32'(tx_data_o), 32'(prev_d));
                end
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: got %0h, no byte expected", tx_data_o);
                    end else begin
                        et = exp_tx.pop_front();
                        chk("tx_byte", 32'(tx_data_o), 32'(et.b));
                        if (et.rd_hi) chk("read_addr", 32'(address_o), 32'(et.a));
                    end
                    got_tx.push_back(tx_data_o);
                end
                prev_v = tx_valid_o;
                prev_r = tx_ready_i;
                prev_d = tx_data_o;
                prev_w = rd_wr_o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a16;
        logic [7:0]  gb;
        int          kind;
        int          n;

        for (int i = 0; i < (1 << AW); i++) begin
            bus_mem[i]   = 16'((i * 40503) ^ 23130);
            model_mem[i] = bus_mem[i];
        end
        bus_mem[5]   = 16'hBEEF;
        model_mem[5] = 16'hBEEF;

        // Reset state
        reset_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_rd_wr", 32'(rd_wr_o), 32'd0);
        chk("reset_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("reset_tx_data", 32'(tx_data_o), 32'd0);
        chk("reset_address", 32'(address_o), 32'd0);
        chk("reset_data", 32'(data_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        reset_ni = 1'b1;
        mon_en   = 1'b1;

        // Single word write
        clear_logs();
        do_write(16'h0002, 16'h1234);
        wait_idle(500);
        chk("t1_nwr", 32'(got_wr.size()), 32'd1);
        if (got_wr.size() > 0) begin
            chk("t1_addr", 32'(got_wr[0].a), 32'h0002);
            chk("t1_data", 32'(got_wr[0].d), 32'h1234);
        end
        chk("t1_ntx", 32'(got_tx.size()), 32'd1);
        if (got_tx.size() > 0) chk("t1_ack", 32'(got_tx[0]), 32'h4B);
        chk("t1_busy", 32'(busy_o), 32'd0);

        // Word read
        clear_logs();
        do_read(16'h0005);
        wait_idle(500);
        chk("t2_nwr", 32'(got_wr.size()), 32'd0);
        chk("t2_ntx", 32'(got_tx.size()), 32'd2);
        if (got_tx.size() == 2) begin
            chk("t2_hi", 32'(got_tx[0]), 32'hBE);
            chk("t2_lo", 32'(got_tx[1]), 32'hEF);
        end
        chk("t2_addr", 32'(address_o), 32'h0005);

        // Burst across the top of the address space
        clear_logs();
        bw.delete();
        bw.push_back(16'hAAAA);
        bw.push_back(16'hBBBB);
        do_burst(16'h7FFF);
        wait_idle(500);
        chk("t3_nwr", 32'(got_wr.size()), 32'd2);
        if (got_wr.size() == 2) begin
            chk("t3_a0", 32'(got_wr[0].a), 32'h7FFF);
            chk("t3_d0", 32'(got_wr[0].d), 32'hAAAA);
            chk("t3_a1", 32'(got_wr[1].a), 32'h0000);
            chk("t3_d1", 32'(got_wr[1].d), 32'hBBBB);
        end
        chk("t3_ntx", 32'(got_tx.size()), 32'd1);

        // Partial command abandoned by timeout
        clear_logs();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h12);
        repeat (90) @(negedge clk_i);
        chk("t4_busy_before_timeout", 32'(busy_o), 32'd1);
        repeat (20) @(negedge clk_i);
        chk("t4_busy_after_timeout", 32'(busy_o), 32'd0);
        chk("t4_nwr", 32'(got_wr.size()), 32'd0);
        chk("t4_ntx", 32'(got_tx.size()), 32'd0);
        do_write(16'h0010, 16'hCAFE);
        wait_idle(500);
        chk("t4_nwr_after", 32'(got_wr.size()), 32'd1);
        chk("t4_ntx_after", 32'(got_tx.size()), 32'd1);

        // Read response under transmitter backpressure, with rx traffic ignored
        clear_logs();
        hold_ready = 1'b1;
        do_read(16'h0005);
        n = 0;
        while (!tx_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("t5_tx_valid_rise", 32'(tx_valid_o), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("t5_hold_valid", 32'(tx_valid_o), 32'd1);
            chk("t5_hold_data", 32'(tx_data_o), 32'hBE);
            rx_valid_i = (i % 3 == 0);
            rx_data_i  = junk[i / 3];
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        hold_ready = 1'b0;
        wait_idle(500);
        chk("t5_ntx", 32'(got_tx.size()), 32'd2);
        if (got_tx.size() == 2) chk("t5_lo", 32'(got_tx[1]), 32'hEF);
        chk("t5_nwr", 32'(got_wr.size()), 32'd0);

        // Asynchronous reset in the middle of a burst
        clear_logs();
        exp_write(AW'(16'h0040), 16'h1357);
        send_byte(8'h42);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h03);
        send_byte(8'h13);
        send_byte(8'h57);
        send_byte(8'h24);
        @(negedge clk_i);
        chk("t6_first_write", 32'(got_wr.size()), 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("t6_rd_wr", 32'(rd_wr_o), 32'd0);
        chk("t6_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_address", 32'(address_o), 32'd0);
        chk("t6_data", 32'(data_o), 32'd0);
        mon_en = 1'b0;
        exp_wr.delete();
        exp_tx.delete();
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        mon_en   = 1'b1;
        send_byte(8'h07);
        repeat (3) @(negedge clk_i);
        chk("t6_ignore_07", 32'(busy_o), 32'd0);
        clear_logs();
        do_read(16'h0040);
        wait_idle(500);
        chk("t6_ntx", 32'(got_tx.size()), 32'd2);
        if (got_tx.size() == 2) begin
            chk("t6_hi", 32'(got_tx[0]), 32'h13);
            chk("t6_lo", 32'(got_tx[1]), 32'h57);
        end

        // Randomized command mix
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(3, 0);
            if ($urandom_range(1, 0) == 1) a16 = 16'($urandom_range(31, 0));
            else a16 = 16'(16'h7FF0 + $urandom_range(15, 0));
            a16[15] = 1'($urandom);
            case (kind)
                0: do_write(a16, 16'($urandom));
                1: begin
                    bw.delete();
                    n = $urandom_range(6, 0);
                    for (int i = 0; i <= n; i++) bw.push_back(16'($urandom));
                    do_burst(a16);
                end
                2: do_read(a16);
                default: begin
                    gb = 8'($urandom);
                    if (gb == 8'h57 || gb == 8'h42 || gb == 8'h52) gb = 8'h00;
                    send_byte(gb);
                    @(negedge clk_i);
                    chk("rand_garbage_idle", 32'(busy_o), 32'd0);
                end
            endcase
            wait_idle(3000);
        end

        // Maximum burst (N=255) wrapping at the top of memory
        clear_logs();
        bw.delete();
        for (int i = 0; i < 256; i++) bw.push_back(16'($urandom));
        do_burst(16'h7F80);
        wait_idle(20000);
        chk("max_burst_nwr", 32'(got_wr.size()), 32'd256);
        chk("max_burst_ntx", 32'(got_tx.size()), 32'd1);
        do_read(16'h7FFF);
        wait_idle(500);
        do_read(16'h007F);
        wait_idle(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
